// File: rtl/nanomips_run_ctrl_pkg.sv
// Shared encodings for the nanoMIPS run/debug sequencer.
//   CMD_*  : host command opcodes
//   state_t: sequencer states
//   HR_*   : halt reason codes reported on halt_reason
package nanomips_run_ctrl_pkg;

   localparam logic [2:0] CMD_NOP       = 3'd0;
   localparam logic [2:0] CMD_LOAD_ADDR = 3'd1;
   localparam logic [2:0] CMD_LOAD_WORD = 3'd2;
   localparam logic [2:0] CMD_RUN       = 3'd3;
   localparam logic [2:0] CMD_STEP      = 3'd4;
   localparam logic [2:0] CMD_HALT      = 3'd5;
   localparam logic [2:0] CMD_SET_BP    = 3'd6;
   localparam logic [2:0] CMD_RESET_CPU = 3'd7;

   typedef enum logic [2:0] {
      S_RESET = 3'd0,
      S_HALT  = 3'd1,
      S_LOAD  = 3'd2,
      S_RUN   = 3'd3,
      S_STEP  = 3'd4
   } state_t;

   localparam logic [1:0] HR_HOST       = 2'd0;
   localparam logic [1:0] HR_STEP_DONE  = 2'd1;
   localparam logic [1:0] HR_BREAKPOINT = 2'd2;
   localparam logic [1:0] HR_WATCHDOG   = 2'd3;

   // SET_BP with this argument disables the breakpoint instead of arming it.
   localparam logic [31:0] BP_DISABLE = 32'hFFFF_FFFF;

endpackage

// File: rtl/nanomips_run_step_counter.sv
// Step budget down-counter for the run sequencer.
//   clk, rst  : clock, async active-high reset
//   load      : load a new step budget (0 is taken as 1)
//   load_val  : requested number of steps
//   dec       : one step executed
//   last      : the step currently executing is the final one
module nanomips_run_step_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        dec,
   output logic        last
);

   logic [31:0] remaining;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining <= '0;
      end else if (load) begin
         remaining <= (load_val == 32'd0) ? 32'd1 : load_val;
      end else if (dec && (remaining != 32'd0)) begin
         remaining <= remaining - 32'd1;
      end
   end

   assign last = (remaining == 32'd1);

endmodule

// File: rtl/nanomips_run_ctrl.sv
// Run/debug sequencer for the single-cycle nanoMIPS CPU (virtual RAM/ROM test build).
// Owns CPU clock-enable and reset, gives the host program-load access to the
// instruction ROM, and runs / steps / halts the CPU on host command or breakpoint.
// Optional watchdog halt is built when RUN_CTRL_WATCHDOG_EN is defined.
//   clk, rst              : clock, async active-high reset
//   host_cmd_valid/ready  : command handshake; host_cmd opcode, host_arg argument
//   cpu_pc                : current CPU PC (byte address)
//   cpu_ce, cpu_rst       : CPU clock enable (combinational) and synchronous reset
//   rom_we/waddr/wdata    : instruction ROM write port
//   halted, halt_reason   : halt status and cause
//   cycle_count           : executed cpu_ce cycles
//
// state   | meaning
// S_RESET | cpu_rst held for RST_CYCLES cycles, commands refused
// S_HALT  | CPU stopped, all commands accepted
// S_LOAD  | one-cycle ROM write of the latched word
// S_RUN   | free run until breakpoint / HALT / RESET_CPU (/ watchdog)
// S_STEP  | run a bounded number of instructions
module nanomips_run_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int RST_CYCLES  = 4,
   parameter int WDOG_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              host_cmd_valid,
   input  logic [2:0]        host_cmd,
   input  logic [31:0]       host_arg,
   output logic              host_cmd_ready,
   input  logic [31:0]       cpu_pc,
   output logic              cpu_ce,
   output logic              cpu_rst,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_waddr,
   output logic [31:0]       rom_wdata,
   output logic              halted,
   output logic [1:0]        halt_reason,
   output logic [31:0]       cycle_count
);

   import nanomips_run_ctrl_pkg::*;

   state_t            state;
   logic [15:0]       rst_cnt;
   logic [ADDR_W-1:0] load_ptr;
   logic [31:0]       load_data;
   logic              bp_en;
   logic [31:0]       bp_addr;
   logic              first_cycle;
   logic              accept;
   logic              active;
   logic              stop_cmd;
   logic              bp_hit;
   logic              wdog_hit;
   logic              step_load;
   logic              step_last;

   assign host_cmd_ready = (state == S_HALT) || (state == S_RUN) || (state == S_STEP);
   assign accept   = host_cmd_valid && host_cmd_ready;
   assign active   = (state == S_RUN) || (state == S_STEP);
   assign stop_cmd = accept && active &&
                     ((host_cmd == CMD_HALT) || (host_cmd == CMD_RESET_CPU));
   // first_cycle masks the breakpoint so a resume executes the instruction it stopped on.
   assign bp_hit   = active && bp_en && (cpu_pc == bp_addr) && !first_cycle;
   assign cpu_ce   = active && !bp_hit && !wdog_hit && !stop_cmd;

   assign cpu_rst   = (state == S_RESET);
   assign halted    = (state == S_HALT);
   assign rom_we    = (state == S_LOAD);
   assign rom_waddr = load_ptr;
   assign rom_wdata = load_data;

   assign step_load = accept && (state == S_HALT) && (host_cmd == CMD_STEP);

   nanomips_run_step_counter u_step_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (step_load),
      .load_val (host_arg),
      .dec      (cpu_ce && (state == S_STEP)),
      .last     (step_last)
   );

`ifdef RUN_CTRL_WATCHDOG_EN
   // Budget of RUN cycles left; reaching zero blocks the next cpu_ce.
   logic [31:0] wdog_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_cnt <= 32'(WDOG_CYCLES);
      end else if (accept && (state == S_HALT) && (host_cmd == CMD_RUN)) begin
         wdog_cnt <= 32'(WDOG_CYCLES);
      end else if (cpu_ce && (state == S_RUN) && (wdog_cnt != 32'd0)) begin
         wdog_cnt <= wdog_cnt - 32'd1;
      end
   end

   assign wdog_hit = (state == S_RUN) && (wdog_cnt == 32'd0);
`else
   logic unused_wdog;
   assign unused_wdog = ^WDOG_CYCLES;
   assign wdog_hit    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_RESET;
         rst_cnt     <= 16'(RST_CYCLES - 1);
         load_ptr    <= '0;
         load_data   <= '0;
         bp_en       <= 1'b0;
         bp_addr     <= '0;
         first_cycle <= 1'b0;
         cycle_count <= '0;
         halt_reason <= HR_HOST;
      end else begin
         first_cycle <= 1'b0;
         if (cpu_ce) begin
            cycle_count <= cycle_count + 32'd1;
         end
         case (state)
            S_RESET: begin
               if (rst_cnt == 16'd0) begin
                  state <= S_HALT;
               end else begin
                  rst_cnt <= rst_cnt - 16'd1;
               end
            end
            S_HALT: begin
               if (accept) begin
                  case (host_cmd)
                     CMD_LOAD_ADDR: load_ptr <= host_arg[ADDR_W-1:0];
                     CMD_LOAD_WORD: begin
                        load_data <= host_arg;
                        state     <= S_LOAD;
                     end
                     CMD_SET_BP: begin
                        bp_addr <= host_arg;
                        bp_en   <= (host_arg != BP_DISABLE);
                     end
                     CMD_RUN: begin
                        state       <= S_RUN;
                        first_cycle <= 1'b1;
                     end
                     CMD_STEP: begin
                        state       <= S_STEP;
                        first_cycle <= 1'b1;
                     end
                     CMD_RESET_CPU: begin
                        state       <= S_RESET;
                        rst_cnt     <= 16'(RST_CYCLES - 1);
                        cycle_count <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            S_LOAD: begin
               load_ptr <= load_ptr + ADDR_W'(1);
               state    <= S_HALT;
            end
            S_RUN, S_STEP: begin
               // Priority: RESET_CPU > breakpoint > watchdog > host HALT > step done.
               if (stop_cmd && (host_cmd == CMD_RESET_CPU)) begin
                  state       <= S_RESET;
                  rst_cnt     <= 16'(RST_CYCLES - 1);
                  cycle_count <= '0;
               end else if (bp_hit) begin
                  state       <= S_HALT;
                  halt_reason <= HR_BREAKPOINT;
               end else if (wdog_hit) begin
                  state       <= S_HALT;
                  halt_reason <= HR_WATCHDOG;
               end else if (stop_cmd) begin
                  state       <= S_HALT;
                  halt_reason <= HR_HOST;
               end else if ((state == S_STEP) && cpu_ce && step_last) begin
                  state       <= S_HALT;
                  halt_reason <= HR_STEP_DONE;
               end
            end
            default: state <= S_RESET;
         endcase
      end
   end

endmodule

// File: tb/tb_nanomips_run_ctrl.sv
// Bench for nanomips_run_ctrl: directed scenarios followed by random host
// commands, all checked cycle by cycle against a behavioural model.
module tb_nanomips_run_ctrl;

   import nanomips_run_ctrl_pkg::*;

   localparam int TB_WDOG = 100;
   localparam int TB_RST  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        host_cmd_valid = 1'b0;
   logic [2:0]  host_cmd = 3'd0;
   logic [31:0] host_arg = 32'd0;
   logic        host_cmd_ready;
   logic [31:0] cpu_pc = 32'd0;
   logic        cpu_ce;
   logic        cpu_rst;
   logic        rom_we;
   logic [7:0]  rom_waddr;
   logic [31:0] rom_wdata;
   logic        halted;
   logic [1:0]  halt_reason;
   logic [31:0] cycle_count;

   always #5 clk = ~clk;

   nanomips_run_ctrl #(.ADDR_W(8), .RST_CYCLES(TB_RST), .WDOG_CYCLES(TB_WDOG)) dut (
      .clk            (clk),
      .rst            (rst),
      .host_cmd_valid (host_cmd_valid),
      .host_cmd       (host_cmd),
      .host_arg       (host_arg),
      .host_cmd_ready (host_cmd_ready),
      .cpu_pc         (cpu_pc),
      .cpu_ce         (cpu_ce),
      .cpu_rst        (cpu_rst),
      .rom_we         (rom_we),
      .rom_waddr      (rom_waddr),
      .rom_wdata      (rom_wdata),
      .halted         (halted),
      .halt_reason    (halt_reason),
      .cycle_count    (cycle_count)
   );

   // Instruction ROM as seen through the write port.
   logic [31:0] rom_seen [256];
   always @(posedge clk) if (rom_we) rom_seen[rom_waddr] <= rom_wdata;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Behavioural model: cycles of reset left, pending ROM write, and whether the
   // CPU is enabled with a step budget (0 = unlimited run).
   int          m_rst_left;
   bit          m_loading;
   bit          m_active;
   int unsigned m_steps;
   bit          m_fresh;
   bit          m_bp_on;
   logic [31:0] m_bp;
   logic [7:0]  m_ptr;
   logic [31:0] m_data;
   logic [31:0] m_count;
   logic [1:0]  m_reason;
   int          m_wd;
   bit e_ready, e_acc, e_stop, e_bp, e_wd, e_ce;

   logic [31:0] pc_q = 32'd0;
   bit          jumpy = 1'b0;

   task automatic model_reset();
      m_rst_left = TB_RST; m_loading = 0; m_active = 0; m_steps = 0; m_fresh = 0;
      m_bp_on = 0; m_bp = 0; m_ptr = 0; m_data = 0; m_count = 0; m_reason = 0; m_wd = 0;
   endtask

   task automatic model_eval();
      e_ready = (m_rst_left == 0) && !m_loading;
      e_acc   = host_cmd_valid && e_ready;
      e_stop  = m_active && e_acc && (host_cmd == CMD_HALT || host_cmd == CMD_RESET_CPU);
      e_bp    = m_active && m_bp_on && (cpu_pc == m_bp) && !m_fresh;
      e_wd    = 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
      e_wd    = m_active && (m_steps == 0) && (m_wd >= TB_WDOG);
`endif
      e_ce    = m_active && !e_bp && !e_wd && !e_stop;
      check_val("cpu_ce", 32'(cpu_ce), 32'(e_ce));
      check_val("cpu_rst", 32'(cpu_rst), 32'(m_rst_left > 0));
      check_val("halted", 32'(halted), 32'(e_ready && !m_active));
      check_val("ready", 32'(host_cmd_ready), 32'(e_ready));
      check_val("rom_we", 32'(rom_we), 32'(m_loading));
      if (m_loading) begin
         check_val("rom_waddr", 32'(rom_waddr), 32'(m_ptr));
         check_val("rom_wdata", rom_wdata, m_data);
      end
      check_val("cycle_count", cycle_count, m_count);
      check_val("halt_reason", 32'(halt_reason), 32'(m_reason));
   endtask

   task automatic model_update();
      if (e_ce) m_count = m_count + 32'd1;
      if (m_rst_left > 0) begin
         m_rst_left--;
      end else if (m_loading) begin
         m_ptr = m_ptr + 8'd1;
         m_loading = 0;
      end else if (!m_active) begin
         if (e_acc) begin
            case (host_cmd)
               CMD_LOAD_ADDR: m_ptr = host_arg[7:0];
               CMD_LOAD_WORD: begin m_data = host_arg; m_loading = 1; end
               CMD_SET_BP:    begin m_bp = host_arg; m_bp_on = (host_arg != 32'hFFFF_FFFF); end
               CMD_RUN:       begin m_active = 1; m_steps = 0; m_fresh = 1; m_wd = 0; end
               CMD_STEP:      begin m_active = 1; m_steps = (host_arg == 0) ? 1 : host_arg; m_fresh = 1; end
               CMD_RESET_CPU: begin m_rst_left = TB_RST; m_count = 0; end
               default: ;
            endcase
         end
      end else begin
         m_fresh = 0;
         if (e_acc && host_cmd == CMD_RESET_CPU) begin
            m_active = 0; m_rst_left = TB_RST; m_count = 0;
         end else if (e_bp) begin
            m_active = 0; m_reason = 2;
         end else if (e_wd) begin
            m_active = 0; m_reason = 3;
         end else if (e_acc && host_cmd == CMD_HALT) begin
            m_active = 0; m_reason = 0;
         end else if (e_ce) begin
            if (m_steps == 0) m_wd++;
            else if (m_steps == 1) begin m_active = 0; m_reason = 1; end
            else m_steps--;
         end
      end
   endtask

   // One clock cycle, entered and left just after a falling edge.
   task automatic tick(input logic v, input logic [2:0] c, input logic [31:0] a);
      logic s_ce, s_rst;
      host_cmd_valid = v; host_cmd = c; host_arg = a; cpu_pc = pc_q;
      #1;
      model_eval();
      s_ce = cpu_ce; s_rst = cpu_rst;
      @(posedge clk);
      model_update();
      if (s_rst) pc_q = 32'd0;
      else if (s_ce) pc_q = (jumpy && $urandom_range(0, 5) == 0) ? 32'd0 : pc_q + 32'd4;
      @(negedge clk);
   endtask

   task automatic issue(input logic [2:0] c, input logic [31:0] a);
      tick(1'b1, c, a);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b0, CMD_NOP, 32'd0);
   endtask

   task automatic wait_halted(input int budget, input string tag, output int n);
      n = 0;
      while (!halted && n < budget) begin
         tick(1'b0, CMD_NOP, 32'd0);
         n++;
      end
      check_val({tag, "_halted"}, 32'(halted), 32'd1);
   endtask

   int n;

   initial begin
      for (int i = 0; i < 256; i++) rom_seen[i] = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      check_val("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check_val("rst_cpu_ce", 32'(cpu_ce), 32'd0);
      check_val("rst_rom_we", 32'(rom_we), 32'd0);
      check_val("rst_halted", 32'(halted), 32'd0);
      check_val("rst_ready", 32'(host_cmd_ready), 32'd0);
      check_val("rst_count", cycle_count, 32'd0);
      rst = 1'b0;
      model_reset();

      wait_halted(10, "por", n);
      check_val("por_len", n, TB_RST);
      check_val("por_reason", 32'(halt_reason), 32'd0);
      check_val("por_count", cycle_count, 32'd0);

      // Program load with pointer wrap.
      issue(CMD_LOAD_ADDR, 32'h10);
      issue(CMD_LOAD_WORD, 32'h2008_0005); idle(1);
      issue(CMD_LOAD_WORD, 32'h0000_0000); idle(1);
      check_val("rom_10", rom_seen[8'h10], 32'h2008_0005);
      check_val("rom_11", rom_seen[8'h11], 32'h0000_0000);
      issue(CMD_LOAD_ADDR, 32'h1FF);
      issue(CMD_LOAD_WORD, 32'hCAFE_0001); idle(1);
      issue(CMD_LOAD_WORD, 32'hCAFE_0002); idle(1);
      check_val("rom_ff", rom_seen[8'hFF], 32'hCAFE_0001);
      check_val("rom_wrap", rom_seen[8'h00], 32'hCAFE_0002);

      // Async reset in the middle of a ROM write.
      issue(CMD_LOAD_WORD, 32'hDEAD_BEEF);
      host_cmd_valid = 1'b0;
      #1;
      check_val("midload_we", 32'(rom_we), 32'd1);
      check_val("midload_addr", 32'(rom_waddr), 32'h01);
      #1 rst = 1'b1;
      #1;
      check_val("midload_drop_we", 32'(rom_we), 32'd0);
      check_val("midload_cpu_rst", 32'(cpu_rst), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      pc_q = 32'd0;
      model_reset();
      wait_halted(10, "midload", n);
      check_val("midload_no_write", rom_seen[8'h01], 32'd0);

      // Stepping.
      issue(CMD_STEP, 32'd3);
      wait_halted(20, "step3", n);
      check_val("step3_count", cycle_count, 32'd3);
      check_val("step3_reason", 32'(halt_reason), 32'd1);
      issue(CMD_STEP, 32'd0);
      wait_halted(20, "step0", n);
      check_val("step0_count", cycle_count, 32'd4);
      check_val("step0_reason", 32'(halt_reason), 32'd1);

      // Breakpoint and resume.
      issue(CMD_RESET_CPU, 32'd0);
      wait_halted(10, "rcpu", n);
      check_val("rcpu_count", cycle_count, 32'd0);
      issue(CMD_SET_BP, 32'h0000_000C);
      issue(CMD_RUN, 32'd0);
      wait_halted(20, "bp", n);
      check_val("bp_reason", 32'(halt_reason), 32'd2);
      check_val("bp_count", cycle_count, 32'd3);
      check_val("bp_pc", pc_q, 32'h0000_000C);
      issue(CMD_RUN, 32'd0);
      idle(1);
      check_val("bp_resume_count", cycle_count, 32'd4);
      issue(CMD_HALT, 32'd0);
      check_val("host_halt_count", cycle_count, 32'd4);
      check_val("host_halt_reason", 32'(halt_reason), 32'd0);

      // Host HALT colliding with a breakpoint hit.
      issue(CMD_RESET_CPU, 32'd0);
      wait_halted(10, "rcpu2", n);
      issue(CMD_SET_BP, 32'h0000_0008);
      issue(CMD_RUN, 32'd0);
      idle(2);
      issue(CMD_HALT, 32'd0);
      check_val("bp_vs_halt_reason", 32'(halt_reason), 32'd2);
      check_val("bp_vs_halt_count", cycle_count, 32'd2);

      // RESET_CPU while running.
      issue(CMD_SET_BP, 32'hFFFF_FFFF);
      issue(CMD_RUN, 32'd0);
      idle(3);
      issue(CMD_RESET_CPU, 32'd0);
      wait_halted(10, "run_rcpu", n);
      check_val("run_rcpu_len", n, TB_RST);
      check_val("run_rcpu_count", cycle_count, 32'd0);

`ifdef RUN_CTRL_WATCHDOG_EN
      issue(CMD_RUN, 32'd0);
      wait_halted(300, "wdog", n);
      check_val("wdog_count", cycle_count, 32'd100);
      check_val("wdog_reason", 32'(halt_reason), 32'd3);
`endif

      // Random host traffic against the model.
      jumpy = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         logic        v;
         logic [2:0]  c;
         logic [31:0] a;
         int          r;
         v = ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 99);
         a = $urandom;
         if (r < 3)       c = CMD_RESET_CPU;
         else if (r < 15) c = CMD_LOAD_ADDR;
         else if (r < 30) c = CMD_LOAD_WORD;
         else if (r < 50) c = CMD_RUN;
         else if (r < 65) begin c = CMD_STEP; a = $urandom_range(0, 6); end
         else if (r < 80) c = CMD_HALT;
         else if (r < 95) begin
            c = CMD_SET_BP;
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : pc_q + 32'(4 * $urandom_range(0, 5));
         end
         else             c = CMD_NOP;
         tick(v, c, a);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/nanomips_run_ctrl.md
Name: nanomips_run_ctrl

Overview:
- Run/debug sequencer for the single-cycle nanoMIPS CPU in the virtual RAM/ROM hardware-test build.
- Owns the CPU clock-enable and CPU reset.
- Gives a host command port program-load access to the instruction ROM.
- Runs, single/multi-steps and halts the CPU on host command, breakpoint or (optionally) watchdog.
- Sits between the host virtual-IO bridge and the CPU top; the CPU runs only when cpu_ce=1.

Parameters:
- ADDR_W, 8, instruction-ROM word-address width.
- RST_CYCLES, 4, number of cycles cpu_rst is held after power-on reset or a RESET_CPU command (>=1).
- WDOG_CYCLES, 1000000, maximum consecutive RUN cycles before a watchdog halt (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- host_cmd_valid  in  1  command strobe.
- host_cmd  in  3  opcode: 0 NOP, 1 LOAD_ADDR, 2 LOAD_WORD, 3 RUN, 4 STEP, 5 HALT, 6 SET_BP, 7 RESET_CPU.
- host_arg  in  32  command argument.
- host_cmd_ready  out  1  command accepted when valid&&ready at a rising edge.
- cpu_pc  in  32  current CPU PC (byte address).
- cpu_ce  out  1  CPU clock enable.
- cpu_rst  out  1  CPU synchronous reset.
- rom_we  out  1  ROM write strobe.
- rom_waddr  out  ADDR_W  ROM word address.
- rom_wdata  out  32  ROM write data.
- halted  out  1  1 in the HALT state.
- halt_reason  out  2  0 HOST, 1 STEP_DONE, 2 BREAKPOINT, 3 WATCHDOG.
- cycle_count  out  32  number of executed cpu_ce cycles.

Behaviour:
- Reset values (async rst):
  - state RESET; cpu_rst=1, cpu_ce=0, rom_we=0.
  - load pointer=0, bp_en=0, bp_addr=0.
  - cycle_count=0, halt_reason=HOST, halted=0, host_cmd_ready=0.
- RESET state:
  - cpu_rst held for RST_CYCLES cycles, then -> HALT (halted=1).
  - Commands are not accepted (ready=0).
- HALT state, ready=1:
  - LOAD_ADDR sets pointer=arg[ADDR_W-1:0].
  - LOAD_WORD -> LOAD state:
    - Next cycle: rom_we=1, rom_waddr=pointer, rom_wdata=arg.
    - Pointer increments, wrapping at 2^ADDR_W; return to HALT.
    - ready=0 during LOAD.
  - SET_BP: bp_addr=arg, bp_en=1. Setting arg=0xFFFFFFFF sets bp_en=0 (disable).
  - RUN -> RUN state.
  - STEP -> STEP state, remaining=arg (arg=0 treated as 1).
  - RESET_CPU -> RESET; cycle_count cleared.
  - HALT and NOP are ignored.
- RUN/STEP states, ready=1:
  - Only HALT and RESET_CPU take effect; other opcodes are accepted and discarded.
- cpu_ce is combinational and equals 1 when all of the following hold:
  - state is RUN or STEP;
  - no bp_hit;
  - no HALT/RESET_CPU being accepted this cycle.
- bp_hit = bp_en && cpu_pc==bp_addr && !first_cycle.
  - first_cycle is 1 in the first cycle after entering RUN/STEP, so resuming from a breakpoint executes that instruction.
- Halt transitions:
  - bp_hit -> HALT, reason BREAKPOINT.
  - Host HALT -> HALT, reason HOST.
  - STEP: remaining decrements per cpu_ce cycle; when remaining==1 and cpu_ce=1 -> HALT next edge, reason STEP_DONE.
- cycle_count increments on every cpu_ce=1 edge and wraps 0xFFFFFFFF->0.
- Simultaneous events:
  - bp_hit and host HALT in the same cycle -> reason BREAKPOINT.
  - bp_hit on the last step -> BREAKPOINT, and the step is not consumed.
  - RESET_CPU beats everything.
- Async rst in any state (including mid-LOAD): the rom_we pulse is dropped immediately and all reset values apply.

Optional Feature:
- Macro: RUN_CTRL_WATCHDOG_EN.
- Defined:
  - A run-length counter clears on RUN entry and counts cpu_ce cycles in RUN.
  - On reaching WDOG_CYCLES, cpu_ce drops that cycle and the block goes to HALT with reason WATCHDOG.
  - Lower priority than breakpoint, higher priority than host HALT.
- Undefined: no counter; reason code 3 is never produced; WDOG_CYCLES is ignored.

Decomposition:
- Package nanomips_run_ctrl_pkg holds:
  - opcode localparams CMD_*;
  - state encodings S_RESET/S_HALT/S_LOAD/S_RUN/S_STEP;
  - halt reason codes HR_*.
- One natural sub-module: nanomips_run_step_counter, the loadable down-counter with zero-as-one load and done flag.

Test Plan:
- Release rst, idle -> cpu_rst=1 for 4 cycles, then halted=1, reason 0, cycle_count=0.
- LOAD_ADDR 0x10, then LOAD_WORD 0x20080005, LOAD_WORD 0x00000000 -> rom_we pulses at addresses 0x10 and 0x11 with the matching data; a third write at pointer 0xFF wraps to 0x00.
- STEP arg=3 -> exactly 3 cpu_ce cycles, cycle_count=3, reason STEP_DONE; STEP arg=0 -> exactly 1 cycle.
- SET_BP 0x0000000C, RUN with PC advancing 0,4,8,C -> cpu_ce low when PC=0xC, reason BREAKPOINT, cycle_count=3. RUN again -> the instruction at 0xC executes.
- HALT issued in the same cycle cpu_pc hits the breakpoint -> reason BREAKPOINT; RESET_CPU during RUN -> cpu_ce=0 at once, cpu_rst for 4 cycles, cycle_count=0.
- With RUN_CTRL_WATCHDOG_EN and WDOG_CYCLES=100, RUN without a breakpoint -> exactly 100 ce cycles, reason WATCHDOG.
